config_chain_tile: RTL and testbench
====================================

// Module: config_chain_tile
// PURPOSE
//   Parametrised configuration tile. A serial scan chain of NUM_SEGS segments of SEG_W bits feeds
//   shadow-protected active configuration registers that drive the tile's logic. Commit is
//   length-checked and staggered one segment per cycle to limit simultaneous config toggling.
//   Capture loads the active config back into the chain for serial readback.
//   Tiles daisy-chain via shift_in/shift_out.
// PARAMETERS
//   SEG_W     8                          bits per config segment
//   NUM_SEGS  4                          segments per tile; chain length L = NUM_SEGS*SEG_W
//   CNT_W     $clog2(NUM_SEGS*SEG_W+2)   width of bit_count
// PORTS
//   clk         in   1             single clock, rising edge
//   rst_n       in   1             asynchronous, active-low reset
//   shift_en    in   1             shift chain one bit this cycle
//   shift_in    in   1             serial config in (from upstream tile)
//   shift_out   out  1             serial out = chain[L-1] (to downstream tile)
//   commit      in   1             request chain -> active transfer
//   seg_mask    in   NUM_SEGS      segments written by commit; sampled with commit
//   capture     in   1             load active config into chain (readback)
//   config_out  out  L             active configuration, segment k = config_out[k*SEG_W +: SEG_W]
//   busy        out  1             commit update in progress
//   done        out  1             1-cycle pulse, commit finished
//   err_len     out  1             sticky: last commit rejected for wrong bit count
//   bit_count   out  CNT_W         shifts since last commit/capture/reset; saturates at L+1
// BEHAVIOUR
//   - Reset (async, rst_n=0): chain, config_out, bit_count, busy, done, err_len, shift_out all 0.
//     FSM -> IDLE. A reset mid-update aborts it: no done pulse, config_out = 0.
//   - Shift (IDLE, shift_en=1): chain <= {chain[L-2:0], shift_in}; bit_count++ (saturating at L+1).
//     A word shifted MSB-first over L cycles ends with chain == word. shift_out is bit L-1 of the
//     registered chain; the first bit in appears at shift_out after L shifts.
//   - Priority in IDLE, same cycle: commit > capture > shift_en. Lower-priority requests are dropped.
//   - Commit with bit_count == L: latch seg_mask; FSM IDLE -> UPD; idx = 0; bit_count <= 0.
//     - In UPD, each edge writes segment idx from the chain if mask[idx], then idx++.
//     - After edge NUM_SEGS: FSM -> IDLE, done = 1 for one cycle, err_len cleared.
//     - With commit sampled at edge E0, segment k is visible after edge E(k+1).
//     - busy is high from after E0 through the cycle before done; busy is low while done is high.
//   - Commit with bit_count != L: no update; err_len <= 1 (sticky); bit_count <= 0; done stays 0;
//     FSM stays IDLE.
//   - Capture (IDLE): chain <= config_out; bit_count <= 0; shift_out shows config_out[L-1] next cycle.
//   - While busy: shift_en, capture and commit are ignored. Chain and bit_count are frozen.
//   - FSM states: IDLE, UPD. UPD -> IDLE only after the last segment is written, or on reset.
//   - Unmasked segments keep their value. seg_mask = 0 still runs the full NUM_SEGS-cycle update
//     and pulses done.
// TESTING  (SEG_W=8, NUM_SEGS=4, L=32)
//   1. Reset, 5 idle cycles -> config_out=0, shift_out=0, busy=0, done=0, err_len=0, bit_count=0.
//   2. Shift 0xA5C30F96 MSB-first (32 cycles), commit with mask 4'hF -> busy for 4 cycles;
//      byte0=0x96 after E1 ... config_out=0xA5C30F96 after E4; done pulses in the cycle after E4.
//   3. Shift 64 bits (first 32 = 0x12345678) -> shift_out replays 0x12345678 on shifts 33..64;
//      then commit -> err_len=1, config_out unchanged, no done.
//   4. From state 0xA5C30F96: shift 0xFFFFFFFF, commit mask 4'b0101 -> config_out=0xA5FF0FFF,
//      err_len cleared.
//   5. Capture, then 32 shifts with shift_in=0 -> shift_out emits config_out MSB-first;
//      shift_en/capture asserted during a commit's busy window have no effect.
//   6. Commit full 0x0BADF00D, assert rst_n=0 after E2 -> config_out=0, busy=0, no done pulse.

Source files
------------

// File: rtl/config_chain_tile.sv
// Configuration tile: serial scan chain feeding shadow-protected active config registers.
// Commits are length-checked and applied one segment per cycle; capture supports serial readback.
//
//   state | meaning
//   IDLE  | chain accepts shift / capture / commit requests
//   UPD   | staggered commit in progress, one segment written per cycle
module config_chain_tile #(
   parameter int SEG_W    = 8,
   parameter int NUM_SEGS = 4,
   parameter int CNT_W    = $clog2(NUM_SEGS*SEG_W+2)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      shift_en,
   input  logic                      shift_in,
   output logic                      shift_out,
   input  logic                      commit,
   input  logic [NUM_SEGS-1:0]       seg_mask,
   input  logic                      capture,
   output logic [NUM_SEGS*SEG_W-1:0] config_out,
   output logic                      busy,
   output logic                      done,
   output logic                      err_len,
   output logic [CNT_W-1:0]          bit_count
);

   localparam int L     = NUM_SEGS*SEG_W;
   localparam int IDX_W = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
   localparam logic [CNT_W-1:0] LEN      = CNT_W'(L);
   localparam logic [CNT_W-1:0] SAT      = CNT_W'(L+1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEGS-1);

   typedef enum logic {IDLE, UPD} state_t;

   state_t              state_q, state_d;
   logic [L-1:0]        chain_q, chain_d;
   logic [L-1:0]        cfg_q, cfg_d;
   logic [CNT_W-1:0]    bit_count_q, bit_count_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_SEGS-1:0] mask_q, mask_d;
   logic                done_q, done_d;
   logic                err_len_q, err_len_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         chain_q     <= '0;
         cfg_q       <= '0;
         bit_count_q <= '0;
         idx_q       <= '0;
         mask_q      <= '0;
         done_q      <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         chain_q     <= chain_d;
         cfg_q       <= cfg_d;
         bit_count_q <= bit_count_d;
         idx_q       <= idx_d;
         mask_q      <= mask_d;
         done_q      <= done_d;
         err_len_q   <= err_len_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      chain_d     = chain_q;
      cfg_d       = cfg_q;
      bit_count_d = bit_count_q;
      idx_d       = idx_q;
      mask_d      = mask_q;
      done_d      = 1'b0;
      err_len_d   = err_len_q;
      case (state_q)
         IDLE: begin
            if (commit) begin
               bit_count_d = '0;
               if (bit_count_q == LEN) begin
                  mask_d  = seg_mask;
                  idx_d   = '0;
                  state_d = UPD;
               end else begin
                  err_len_d = 1'b1;
               end
            end else if (capture) begin
               chain_d     = cfg_q;
               bit_count_d = '0;
            end else if (shift_en) begin
               chain_d = {chain_q[L-2:0], shift_in};
               if (bit_count_q != SAT) bit_count_d = bit_count_q + 1'b1;
            end
         end
         UPD: begin
            // Chain and bit_count stay frozen; only the indexed segment may change this cycle.
            for (int k = 0; k < NUM_SEGS; k++) begin
               if ((int'(idx_q) == k) && mask_q[k])
                  cfg_d[k*SEG_W +: SEG_W] = chain_q[k*SEG_W +: SEG_W];
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               err_len_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign shift_out  = chain_q[L-1];
   assign config_out = cfg_q;
   assign busy       = (state_q == UPD);
   assign done       = done_q;
   assign err_len    = err_len_q;
   assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_config_chain_tile.sv
// Directed bench for config_chain_tile (SEG_W=8, NUM_SEGS=4, chain length 32).
module tb_config_chain_tile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        shift_en;
   logic        shift_in;
   logic        shift_out;
   logic        commit;
   logic [3:0]  seg_mask;
   logic        capture;
   logic [31:0] config_out;
   logic        busy;
   logic        done;
   logic        err_len;
   logic [5:0]  bit_count;

   int tests = 0;
   int fails = 0;

   config_chain_tile #(.SEG_W(8), .NUM_SEGS(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en   (shift_en),
      .shift_in   (shift_in),
      .shift_out  (shift_out),
      .commit     (commit),
      .seg_mask   (seg_mask),
      .capture    (capture),
      .config_out (config_out),
      .busy       (busy),
      .done       (done),
      .err_len    (err_len),
      .bit_count  (bit_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic shift_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) begin
         shift_en = 1'b1;
         shift_in = w[i];
         tick();
      end
      shift_en = 1'b0;
      shift_in = 1'b0;
   endtask

   task automatic do_commit(input logic [3:0] m);
      commit   = 1'b1;
      seg_mask = m;
      tick();
      commit   = 1'b0;
      seg_mask = 4'h0;
   endtask

   logic [31:0] word_a;
   logic [31:0] word_b;
   logic [31:0] collected;

   initial begin
      rst_n    = 1'b0;
      shift_en = 1'b0;
      shift_in = 1'b0;
      commit   = 1'b0;
      seg_mask = 4'h0;
      capture  = 1'b0;

      // 1. reset and idle
      #2;
      check("rst_cfg_async", {32'h0, config_out}, 64'h0);
      tick(); tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("idle_cfg",      {32'h0, config_out}, 64'h0);
      check("idle_shiftout", {63'h0, shift_out},  64'h0);
      check("idle_busy",     {63'h0, busy},       64'h0);
      check("idle_done",     {63'h0, done},       64'h0);
      check("idle_err",      {63'h0, err_len},    64'h0);
      check("idle_cnt",      {58'h0, bit_count},  64'h0);

      // 2. full commit, staggered segment visibility
      shift_word(32'hA5C30F96);
      check("t2_cnt32", {58'h0, bit_count}, 64'd32);
      do_commit(4'hF);
      check("t2_e0_busy", {63'h0, busy},       64'h1);
      check("t2_e0_cfg",  {32'h0, config_out}, 64'h0);
      check("t2_e0_cnt",  {58'h0, bit_count},  64'h0);
      tick();
      check("t2_e1_cfg",  {32'h0, config_out}, 64'h0000_0096);
      check("t2_e1_busy", {63'h0, busy},       64'h1);
      tick();
      check("t2_e2_cfg",  {32'h0, config_out}, 64'h0000_0F96);
      tick();
      check("t2_e3_cfg",  {32'h0, config_out}, 64'h00C3_0F96);
      check("t2_e3_done", {63'h0, done},       64'h0);
      tick();
      check("t2_e4_cfg",  {32'h0, config_out}, 64'hA5C3_0F96);
      check("t2_e4_busy", {63'h0, busy},       64'h0);
      check("t2_e4_done", {63'h0, done},       64'h1);
      tick();
      check("t2_done_pulse", {63'h0, done}, 64'h0);

      // 3. over-length shift: pass-through replay and rejected commit
      word_a = 32'h12345678;
      word_b = 32'hDEADBEEF;
      shift_word(word_a);
      collected = 32'h0;
      for (int j = 0; j < 32; j++) begin
         collected = {collected[30:0], shift_out};
         shift_en  = 1'b1;
         shift_in  = word_b[31-j];
         tick();
      end
      shift_en = 1'b0;
      check("t3_replay", {32'h0, collected}, 64'h1234_5678);
      check("t3_cnt_sat", {58'h0, bit_count}, 64'd33);
      do_commit(4'hF);
      check("t3_err",  {63'h0, err_len},    64'h1);
      check("t3_busy", {63'h0, busy},       64'h0);
      check("t3_cnt0", {58'h0, bit_count},  64'h0);
      tick();
      check("t3_nodone", {63'h0, done},       64'h0);
      check("t3_cfg",    {32'h0, config_out}, 64'hA5C3_0F96);

      // 4. partial mask commit clears err_len
      shift_word(32'hFFFFFFFF);
      do_commit(4'b0101);
      repeat (4) tick();
      check("t4_cfg",  {32'h0, config_out}, 64'hA5FF_0FFF);
      check("t4_done", {63'h0, done},       64'h1);
      check("t4_err",  {63'h0, err_len},    64'h0);

      // 5. capture readback, then requests ignored while busy
      capture = 1'b1;
      tick();
      capture = 1'b0;
      check("t5_cap_so",  {63'h0, shift_out}, 64'h1);
      check("t5_cap_cnt", {58'h0, bit_count}, 64'h0);
      collected = 32'h0;
      for (int j = 0; j < 32; j++) begin
         collected = {collected[30:0], shift_out};
         shift_en  = 1'b1;
         shift_in  = 1'b0;
         tick();
      end
      shift_en = 1'b0;
      check("t5_readback", {32'h0, collected}, 64'hA5FF_0FFF);
      check("t5_chain0",   {63'h0, shift_out}, 64'h0);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      shift_word(32'h13579BDF);
      do_commit(4'hF);
      shift_en = 1'b1;
      shift_in = 1'b1;
      capture  = 1'b1;
      commit   = 1'b1;
      seg_mask = 4'h0;
      repeat (4) tick();
      shift_en = 1'b0;
      shift_in = 1'b0;
      capture  = 1'b0;
      commit   = 1'b0;
      check("t5_busy_cfg",  {32'h0, config_out}, 64'h1357_9BDF);
      check("t5_busy_done", {63'h0, done},       64'h1);
      check("t5_busy_cnt",  {58'h0, bit_count},  64'h0);
      check("t5_busy_so",   {63'h0, shift_out},  64'h0);
      check("t5_busy_err",  {63'h0, err_len},    64'h0);

      // 6. reset in the middle of an update
      shift_word(32'h0BADF00D);
      do_commit(4'hF);
      tick();
      check("t6_e1_cfg", {32'h0, config_out}, 64'h1357_9B0D);
      tick();
      check("t6_e2_cfg", {32'h0, config_out}, 64'h1357_F00D);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_cfg",  {32'h0, config_out}, 64'h0);
      check("t6_rst_busy", {63'h0, busy},       64'h0);
      check("t6_rst_done", {63'h0, done},       64'h0);
      check("t6_rst_cnt",  {58'h0, bit_count},  64'h0);
      tick(); tick();
      check("t6_hold_done", {63'h0, done}, 64'h0);
      rst_n = 1'b1;
      tick();
      check("t6_post_done", {63'h0, done},       64'h0);
      check("t6_post_busy", {63'h0, busy},       64'h0);
      check("t6_post_cfg",  {32'h0, config_out}, 64'h0);
      tick();
      check("t6_post2_done", {63'h0, done}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
